// File: rtl/bitmanip_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bitmanip_pkg
// Description : Shared types and helpers for the bit-manipulation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bitmanip_pkg;

   typedef enum logic [1:0] {
      CLMUL  = 2'b00,
      CLMULH = 2'b01,
      CLMULR = 2'b10,
      RSVD   = 2'b11
   } clmul_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } clmul_state_e;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clmul_step.sv
`default_nettype none
// ============================================================================
// Module      : clmul_step
// Description : One STEP-bit slice of a carry-less multiply (partial XOR).
// Revision    : 1.0 - initial release
// ============================================================================
module clmul_step
   import bitmanip_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 4
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [2*XLEN-1:0] a,
   input  logic [STEP-1:0]   b,
   output logic [2*XLEN-1:0] acc_next
);

   always_comb begin
      acc_next = acc;
      for (int i = 0; i < STEP; i++) begin
         if (b[i]) begin
            acc_next = acc_next ^ (a << i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/clmul_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : clmul_seq_unit
// Description : Multi-cycle clmul/clmulh/clmulr engine with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
module clmul_seq_unit
   import bitmanip_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int STEP       = 4,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [1:0]      mode,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd,
   output logic            busy
);

   localparam int               NSTEPS   = XLEN / STEP;
   localparam int               CNT_W    = clog2(NSTEPS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

   generate
      if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
         $error("clmul_seq_unit: XLEN must be 32 or 64");
      end
      if (STEP < 1 || STEP > XLEN || (STEP & (STEP - 1)) != 0 || (XLEN % STEP) != 0) begin : g_bad_step
         $error("clmul_seq_unit: STEP must be a power of two dividing XLEN");
      end
   endgenerate

   clmul_state_e      state_q, state_d;
   clmul_mode_e       mode_q, mode_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] a_q, a_d;
   logic [2*XLEN-1:0] step_acc;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   b_shift;
   logic [XLEN-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]   result;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic              run_last;

   clmul_step #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_step (
      .acc      (acc_q),
      .a        (a_q),
      .b        (b_q[STEP-1:0]),
      .acc_next (step_acc)
   );

   assign b_shift   = b_q >> STEP;
   assign run_last  = (count_q == LAST_CNT) || (EARLY_EXIT && (b_shift == '0));
   // Held low while in reset so nothing is offered before the engine is live.
   assign in_ready  = rst && (state_q == IDLE) && !kill;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign rd        = rd_q;

   always_comb begin
      result = '0;
      case (mode_q)
         CLMUL:   result = step_acc[XLEN-1:0];
         CLMULH:  result = step_acc[2*XLEN-1:XLEN];
         CLMULR:  result = step_acc[2*XLEN-2:XLEN-1];
         default: result = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      count_d     = count_q;
      rd_d        = rd_q;
      out_valid_d = out_valid_q;
      if (kill) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state_d = RUN;
                  mode_d  = clmul_mode_e'(mode);
                  acc_d   = '0;
                  a_d     = {{XLEN{1'b0}}, rs1};
                  b_d     = rs2;
                  count_d = '0;
               end
            end
            RUN: begin
               acc_d   = step_acc;
               a_d     = a_q << STEP;
               b_d     = b_shift;
               count_d = count_q + CNT_W'(1);
               if (run_last) begin
                  state_d     = DONE;
                  rd_d        = result;
                  out_valid_d = 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mode_q      <= CLMUL;
         acc_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         count_q     <= '0;
         rd_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         count_q     <= count_d;
         rd_q        <= rd_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clmul_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_clmul_seq_unit
// Description : Self-checking bench for three clmul_seq_unit configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clmul_seq_unit;

   localparam int NI = 3;
   localparam int XL [NI] = '{32, 32, 64};
   localparam int ST [NI] = '{4, 4, 8};
   localparam bit EE [NI] = '{1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        kill;
   logic        out_ready;
   logic [1:0]  mode;
   logic [63:0] rs1;
   logic [63:0] rs2;

   logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
   logic [31:0] rd0, rd1;
   logic [63:0] rd2;
   wire  [2:0]  ir = {ir2, ir1, ir0};
   wire  [2:0]  ov = {ov2, ov1, ov0};
   wire  [2:0]  bz = {bz2, bz1, bz0};

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   clmul_seq_unit #(.XLEN(32), .STEP(4), .EARLY_EXIT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .rs1(rs1[31:0]), .rs2(rs2[31:0]), .mode(mode), .kill(kill),
      .out_valid(ov0), .out_ready(out_ready), .rd(rd0), .busy(bz0));

   clmul_seq_unit #(.XLEN(32), .STEP(4), .EARLY_EXIT(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
      .rs1(rs1[31:0]), .rs2(rs2[31:0]), .mode(mode), .kill(kill),
      .out_valid(ov1), .out_ready(out_ready), .rd(rd1), .busy(bz1));

   clmul_seq_unit #(.XLEN(64), .STEP(8), .EARLY_EXIT(1'b0)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
      .rs1(rs1), .rs2(rs2), .mode(mode), .kill(kill),
      .out_valid(ov2), .out_ready(out_ready), .rd(rd2), .busy(bz2));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] msk(input int xl);
      return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] get_rd(input int i);
      case (i)
         0:       return {32'b0, rd0};
         1:       return {32'b0, rd1};
         default: return rd2;
      endcase
   endfunction

   // Polynomial product over GF(2): bit k is the parity of a[i]&b[k-i].
   function automatic logic [63:0] ref_result(input logic [63:0] a_in, input logic [63:0] b_in,
                                              input int xl, input logic [1:0] m);
      logic [63:0]  a;
      logic [63:0]  b;
      logic [127:0] p;
      a = a_in & msk(xl);
      b = b_in & msk(xl);
      p = '0;
      for (int k = 0; k < 2 * xl; k++) begin
         for (int i = 0; i < xl; i++) begin
            if (k - i >= 0 && k - i < xl) p[k] = p[k] ^ (a[i] & b[k-i]);
         end
      end
      case (m)
         2'b00:   return p[63:0] & msk(xl);
         2'b01:   return 64'(p >> xl) & msk(xl);
         2'b10:   return 64'(p >> (xl - 1)) & msk(xl);
         default: return '0;
      endcase
   endfunction

   function automatic int lat_of(input logic [63:0] b_in, input int xl, input int st, input bit ee);
      int          top;
      logic [63:0] b;
      b   = b_in & msk(xl);
      top = -1;
      if (!ee) return xl / st;
      for (int i = 0; i < xl; i++) if (b[i]) top = i;
      if (top < 0) return 1;
      return (top + st) / st;
   endfunction

   // Transaction-level model: idle(0) / computing(1) / result held(2).
   int          m_phase [NI];
   int          m_left  [NI];
   logic [63:0] m_res   [NI];

   initial for (int i = 0; i < NI; i++) begin
      m_phase[i] = 0;
      m_left[i]  = 0;
      m_res[i]   = '0;
   end

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst) m_phase[i] <= 0;
         else if (kill) m_phase[i] <= 0;
         else begin
            case (m_phase[i])
               0: if (in_valid) begin
                  m_phase[i] <= 1;
                  m_left[i]  <= lat_of(rs2, XL[i], ST[i], EE[i]);
                  m_res[i]   <= ref_result(rs1, rs2, XL[i], mode);
               end
               1: begin
                  m_left[i] <= m_left[i] - 1;
                  if (m_left[i] == 1) m_phase[i] <= 2;
               end
               default: if (out_ready) m_phase[i] <= 0;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d out_valid", i), 64'(ov[i]), 64'(rst && m_phase[i] == 2));
         chk($sformatf("u%0d busy", i), 64'(bz[i]), 64'(rst && m_phase[i] != 0));
         chk($sformatf("u%0d in_ready", i), 64'(ir[i]), 64'(rst && m_phase[i] == 0 && !kill));
         if (!rst) chk($sformatf("u%0d rd in reset", i), get_rd(i), 64'h0);
         else if (m_phase[i] == 2) chk($sformatf("u%0d rd", i), get_rd(i), m_res[i]);
      end
   end

   int lat [NI];

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m);
      rs1 = a; rs2 = b; mode = m;
      in_valid = 1'b1; kill = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < NI; i++) lat[i] = -1;
      for (int e = 1; e <= 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); e++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NI; i++) if (lat[i] < 0 && ov[i]) lat[i] = e;
      end
      for (int i = 0; i < NI; i++) chk($sformatf("u%0d result arrived", i), 64'(lat[i] >= 0), 64'h1);
   endtask

   task automatic release_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [31:0] exp_msb [4];

   initial begin
      rst = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
      mode = 2'b00; rs1 = '0; rs2 = '0;
      exp_msb = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000};
      repeat (3) @(posedge clk);
      #1;
      chk("reset rd0", {32'b0, rd0}, 64'h0);
      chk("reset rd2", rd2, 64'h0);
      chk("reset out_valid0", 64'(ov0), 64'h0);
      chk("reset busy0", 64'(bz0), 64'h0);
      rst = 1'b1;
      #1;
      chk("in_ready after reset", 64'(ir0), 64'h1);

      run_op(64'h3, 64'h3, 2'b00);
      chk("u0 latency 3x3", 64'(lat[0]), 64'd8);
      chk("u0 clmul 3x3", {32'b0, rd0}, 64'h5);
      chk("u1 early latency 3x3", 64'(lat[1]), 64'd1);
      chk("u2 clmul 3x3", rd2, 64'h5);
      release_op();
      run_op(64'h3, 64'h3, 2'b01);
      chk("u0 clmulh 3x3", {32'b0, rd0}, 64'h0);
      release_op();

      for (int m = 0; m < 4; m++) begin
         run_op(64'h8000_0000, 64'h8000_0000, 2'(m));
         chk($sformatf("u0 msb mode %0d", m), {32'b0, rd0}, {32'b0, exp_msb[m]});
         release_op();
      end

      run_op(64'h1234_5678, 64'h9ABC_DEF0, 2'b00);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("backpressure out_valid0", 64'(ov0), 64'h1);
         chk("backpressure rd0", {32'b0, rd0}, ref_result(64'h1234_5678, 64'h9ABC_DEF0, 32, 2'b00));
         chk("backpressure in_ready0", 64'(ir0), 64'h0);
         chk("backpressure busy0", 64'(bz0), 64'h1);
      end
      release_op();
      chk("after accept in_ready0", 64'(ir0), 64'h1);
      chk("after accept busy0", 64'(bz0), 64'h0);

      run_op(64'hFFFF_FFFF, 64'h1, 2'b00);
      chk("u1 latency rs2=1", 64'(lat[1]), 64'd1);
      chk("u1 rd ones x 1", {32'b0, rd1}, 64'hFFFF_FFFF);
      release_op();
      run_op(64'h5, 64'h0001_0000, 2'b00);
      chk("u1 latency bit16", 64'(lat[1]), 64'd5);
      chk("u1 rd bit16", {32'b0, rd1}, 64'h0005_0000);
      release_op();
      run_op(64'h7, 64'h0, 2'b00);
      chk("u1 latency rs2=0", 64'(lat[1]), 64'd1);
      chk("u1 rd rs2=0", {32'b0, rd1}, 64'h0);
      release_op();

      rs1 = 64'h0F0F; rs2 = 64'h8000_0001; mode = 2'b00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill busy0", 64'(bz0), 64'h0);
      chk("kill out_valid0", 64'(ov0), 64'h0);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("killed op silent", 64'(ov), 64'h0);
      end
      in_valid = 1'b1; kill = 1'b1;
      #1;
      chk("kill idle in_ready0", 64'(ir0), 64'h0);
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      chk("kill idle no accept", 64'(bz), 64'h0);
      run_op(64'h3, 64'h3, 2'b00);
      chk("post-kill rd0", {32'b0, rd0}, 64'h5);
      chk("post-kill latency", 64'(lat[0]), 64'd8);
      release_op();

      rs1 = 64'hFFFF_FFFF_FFFF_FFFF; rs2 = 64'hFFFF_FFFF_FFFF_FFFF; mode = 2'b01;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("async reset busy", 64'(bz), 64'h0);
      chk("async reset out_valid", 64'(ov), 64'h0);
      chk("async reset in_ready", 64'(ir), 64'h0);
      chk("async reset rd0", {32'b0, rd0}, 64'h0);
      chk("async reset rd2", rd2, 64'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
      chk("u2 clmulh ones", rd2, 64'h5555_5555_5555_5555);
      chk("u0 clmulh ones", {32'b0, rd0}, 64'h5555_5555);
      release_op();

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 2) != 0);
         kill      = ($urandom_range(0, 39) == 0);
         mode      = 2'($urandom_range(0, 3));
         rs1       = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       rs2 = '0;
            1:       rs2 = 64'h1 << $urandom_range(0, 63);
            2:       rs2 = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: rs2 = {$urandom, $urandom};
         endcase
      end
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
